ddr_wr_arb: RTL and testbench
=============================

// Module: ddr_wr_arb
// PURPOSE
//  Round-robin arbiter sharing one DDR write-path FIFO among NREQ burst writers (bm_obuf2 and peer
//  output buffers). Grants one requester at a time via the dwr_req/dwr_ack handshake, forwards its
//  CMD/ADDR/DATA word stream, tracks packet length from the CMD word, and grants only when the
//  downstream FIFO can take a full packet. A granted packet is never stalled.
// PARAMETERS
//  NREQ    4   number of requesters (2..8)
//  MAXLEN  18  max packet words = CMD + ADDR + 16 DATA; grant needs m_free >= MAXLEN
//  FW      10  width of m_free
// PORTS
//  clk         in   1         clock
//  rst_n       in   1         asynchronous reset, active low
//  enb         in   1         0: synchronous return to IDLE, clears pointer and status
//  dwr_req     in   NREQ      per-requester request
//  dwr_ack     out  NREQ      per-requester grant/ack, one-hot or zero
//  dwr_vout    in   NREQ      per-requester word valid (= req & ack at requester)
//  dwr_dout    in   32*NREQ   per-requester word, slice i = [32*i+31:32*i]
//  dwr_strb    in   4*NREQ    per-requester byte strobes
//  m_free      in   FW        free words in downstream write FIFO
//  m_vout      out  1         forwarded word valid
//  m_dout      out  32        forwarded word
//  m_strb      out  4         forwarded strobes
//  m_sop       out  1         m_vout word is CMD
//  m_eop       out  1         m_vout word is last DATA
//  gnt_id      out  3         index of current/last granted requester
//  busy        out  1         state != IDLE
//  err_len     out  1         sticky: req dropped before expected words, or vout after count done
// BEHAVIOUR
//  Reset (rst_n=0) and enb=0: state=IDLE, dwr_ack=0, m_* =0, gnt_id=0, busy=0, err_len=0, rr_ptr=0.
//  Packet format from requester: word0 CMD, bits[3:0]=data_words-1; word1 ADDR; then data_words DATA.
//  Expected count exp = CMD[3:0] + 3 (CMD+ADDR+DATA); 4-bit field gives 3..18 words.
//  States:
//   IDLE  : if |dwr_req and m_free >= MAXLEN, pick first set req at or after rr_ptr (wrapping at NREQ);
//           register gnt_id, dwr_ack[gnt_id]<=1, go GRANT. Otherwise stay.
//   GRANT : wait dwr_vout[gnt_id]; that first word is CMD: latch exp, wcnt<=1, m_sop=1, go XFER.
//           If dwr_req[gnt_id] drops first: err_len<=1, ack<=0, go DONE.
//   XFER  : each vout word wcnt++. On word where wcnt+1==exp: m_eop=1, ack<=0, go DONE.
//           req drop while wcnt<exp: err_len<=1, ack<=0, go DONE.
//   DONE  : ack=0; wait dwr_req[gnt_id]==0 (requester clears req one cycle after last word);
//           rr_ptr<=gnt_id+1 (wrap to 0 at NREQ); go IDLE. vout seen here: err_len<=1, word dropped.
//  Forwarding is combinational, no stall: m_vout = dwr_vout[gnt_id] & ack_q & state in {GRANT,XFER};
//   m_dout/m_strb = granted slice when m_vout else 0. Non-granted vout ignored.
//  Minimum gap between grants: 1 IDLE cycle after DONE. m_free is sampled only in IDLE;
//   downstream must not consume reserved space assumption mid-packet.
//  Simultaneous requests: round-robin from rr_ptr; single requester may be re-granted back to back.
//  enb falling mid-packet: abort to IDLE next cycle, ack=0; partial packet is not flagged.
// TESTING
//  1 req0 only, m_free=64, CMD=0x0F -> ack0 after 1 cycle; 18 m_vout words; m_sop on w0, m_eop on w17; ack0 low after w17.
//  2 req0..3 held continuously -> gnt_id sequence 0,1,2,3,0; each packet 18 words, no word interleaving.
//  3 req1 with m_free=17 -> no ack; raise m_free to 18 -> ack1 next cycle.
//  4 req2 CMD=0x0F, req dropped after 10 words -> err_len=1, ack2=0, return IDLE; next grant normal.
//  5 CMD=0x03 (4 data) -> 6 words, m_eop on word 6; requester forcing 7th vout -> err_len=1, m_vout=0.
//  6 enb=0 mid XFER -> ack=0, busy=0 next cycle, rr_ptr=0, err_len=0; rst_n async low same result.

Source files
------------

// File: rtl/ddr_wr_arb.sv
// Round-robin arbiter sharing one DDR write FIFO among NREQ burst writers.
// Grants a whole packet at a time and forwards the granted word stream unstalled.
module ddr_wr_arb #(
   parameter int NREQ   = 4,
   parameter int MAXLEN = 18,
   parameter int FW     = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enb,
   input  logic [NREQ-1:0]   dwr_req,
   output logic [NREQ-1:0]   dwr_ack,
   input  logic [NREQ-1:0]   dwr_vout,
   input  logic [32*NREQ-1:0] dwr_dout,
   input  logic [4*NREQ-1:0] dwr_strb,
   input  logic [FW-1:0]     m_free,
   output logic              m_vout,
   output logic [31:0]       m_dout,
   output logic [3:0]        m_strb,
   output logic              m_sop,
   output logic              m_eop,
   output logic [2:0]        gnt_id,
   output logic              busy,
   output logic              err_len
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_XFER,
      S_DONE
   } state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic [NREQ-1:0] r_ack;
   logic [NREQ-1:0] w_ack_nx;
   logic [2:0]      r_gnt;
   logic [2:0]      w_gnt_nx;
   logic [2:0]      r_rr;
   logic [2:0]      w_rr_nx;
   logic [4:0]      r_exp;
   logic [4:0]      w_exp_nx;
   logic [4:0]      r_wcnt;
   logic [4:0]      w_wcnt_nx;
   logic            r_err;
   logic            w_err_nx;

   logic            w_req_g;
   logic            w_vout_g;
   logic            w_ack_g;
   logic [31:0]     w_dout_g;
   logic [3:0]      w_strb_g;
   logic            w_fwd;
   logic            w_last;
   logic            w_pick_ok;
   logic [2:0]      w_pick;
   logic [2:0]      w_rr_wrap;
   int              w_j;

   always_comb begin
      w_req_g  = 1'b0;
      w_vout_g = 1'b0;
      w_ack_g  = 1'b0;
      w_dout_g = '0;
      w_strb_g = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (r_gnt == 3'(i)) begin
            w_req_g  = dwr_req[i];
            w_vout_g = dwr_vout[i];
            w_ack_g  = r_ack[i];
            w_dout_g = dwr_dout[32*i +: 32];
            w_strb_g = dwr_strb[4*i +: 4];
         end
      end
   end

   // first set request at or after the round-robin pointer, wrapping at NREQ
   always_comb begin
      w_pick_ok = 1'b0;
      w_pick    = '0;
      w_j       = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_j = int'(r_rr) + k;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (!w_pick_ok && w_j == i && dwr_req[i]) begin
               w_pick_ok = 1'b1;
               w_pick    = 3'(i);
            end
         end
      end
   end

   assign w_fwd = enb & w_vout_g & w_ack_g &
                  (r_state == S_GRANT || r_state == S_XFER);
   assign w_last = (r_wcnt + 5'd1) == r_exp;
   assign w_rr_wrap = (r_gnt == 3'(NREQ-1)) ? 3'd0 : r_gnt + 3'd1;

   always_comb begin
      w_state_nx = r_state;
      w_ack_nx   = r_ack;
      w_gnt_nx   = r_gnt;
      w_rr_nx    = r_rr;
      w_exp_nx   = r_exp;
      w_wcnt_nx  = r_wcnt;
      w_err_nx   = r_err;
      if (!enb) begin
         w_state_nx = S_IDLE;
         w_ack_nx   = '0;
         w_gnt_nx   = '0;
         w_rr_nx    = '0;
         w_exp_nx   = '0;
         w_wcnt_nx  = '0;
         w_err_nx   = 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_pick_ok && m_free >= FW'(MAXLEN)) begin
                  w_gnt_nx   = w_pick;
                  w_ack_nx   = NREQ'(1) << w_pick;
                  w_state_nx = S_GRANT;
               end
            end
            S_GRANT: begin
               if (w_fwd) begin
                  w_exp_nx   = {1'b0, w_dout_g[3:0]} + 5'd3;
                  w_wcnt_nx  = 5'd1;
                  w_state_nx = S_XFER;
               end else if (!w_req_g) begin
                  w_err_nx   = 1'b1;
                  w_ack_nx   = '0;
                  w_state_nx = S_DONE;
               end
            end
            S_XFER: begin
               if (w_fwd) begin
                  w_wcnt_nx = r_wcnt + 5'd1;
                  if (w_last) begin
                     w_ack_nx   = '0;
                     w_state_nx = S_DONE;
                  end
               end else if (!w_req_g) begin
                  w_err_nx   = 1'b1;
                  w_ack_nx   = '0;
                  w_state_nx = S_DONE;
               end
            end
            S_DONE: begin
               // a word offered after the count is done is dropped
               if (w_vout_g) w_err_nx = 1'b1;
               if (!w_req_g) begin
                  w_rr_nx    = w_rr_wrap;
                  w_state_nx = S_IDLE;
               end
            end
            default: w_state_nx = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_ack   <= '0;
         r_gnt   <= '0;
         r_rr    <= '0;
         r_exp   <= '0;
         r_wcnt  <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_ack   <= w_ack_nx;
         r_gnt   <= w_gnt_nx;
         r_rr    <= w_rr_nx;
         r_exp   <= w_exp_nx;
         r_wcnt  <= w_wcnt_nx;
         r_err   <= w_err_nx;
      end
   end

   assign dwr_ack = r_ack;
   assign m_vout  = w_fwd;
   assign m_dout  = w_fwd ? w_dout_g : '0;
   assign m_strb  = w_fwd ? w_strb_g : '0;
   assign m_sop   = w_fwd & (r_state == S_GRANT);
   assign m_eop   = w_fwd & (r_state == S_XFER) & w_last;
   assign gnt_id  = r_gnt;
   assign busy    = (r_state != S_IDLE);
   assign err_len = r_err;

endmodule

// File: tb/tb_ddr_wr_arb.sv
// Bench for ddr_wr_arb: requester models, packet-level scoreboard,
// vector table, directed corner sequences and a randomized run.
module tb_ddr_wr_arb;
   localparam int NREQ   = 4;
   localparam int MAXLEN = 18;
   localparam int FW     = 10;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 enb;
   logic [NREQ-1:0]      dwr_req;
   logic [NREQ-1:0]      dwr_ack;
   logic [NREQ-1:0]      dwr_vout;
   logic [32*NREQ-1:0]   dwr_dout;
   logic [4*NREQ-1:0]    dwr_strb;
   logic [FW-1:0]        m_free;
   logic                 m_vout;
   logic [31:0]          m_dout;
   logic [3:0]           m_strb;
   logic                 m_sop;
   logic                 m_eop;
   logic [2:0]           gnt_id;
   logic                 busy;
   logic                 err_len;

   always #5 clk = ~clk;

   ddr_wr_arb #(.NREQ(NREQ), .MAXLEN(MAXLEN), .FW(FW)) dut (
      .clk(clk), .rst_n(rst_n), .enb(enb),
      .dwr_req(dwr_req), .dwr_ack(dwr_ack), .dwr_vout(dwr_vout),
      .dwr_dout(dwr_dout), .dwr_strb(dwr_strb), .m_free(m_free),
      .m_vout(m_vout), .m_dout(m_dout), .m_strb(m_strb),
      .m_sop(m_sop), .m_eop(m_eop), .gnt_id(gnt_id),
      .busy(busy), .err_len(err_len)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // requester models
   logic [31:0] pw [NREQ][18];
   int  len [NREQ];
   int  idx [NREQ];
   int  drop_at [NREQ];
   int  q_cnt [NREQ];
   bit  act [NREQ];
   bit  xtra [NREQ];
   bit  xdone [NREQ];

   // scoreboard state
   logic [NREQ-1:0] p_ack;
   logic [NREQ-1:0] s_req;
   logic [FW-1:0]   s_free;
   int  mrr = 0;
   int  pend = -1;
   int  owner = -1;
   int  k = 0;
   int  fwd_cnt = 0;
   int  done_cnt [NREQ];
   int  glog [$];

   function automatic logic [3:0] sb(logic [31:0] w);
      return w[7:4] ^ w[11:8];
   endfunction

   function automatic int pick(logic [NREQ-1:0] r, int p);
      for (int n = 0; n < NREQ; n++)
         if (r[(p + n) % NREQ]) return (p + n) % NREQ;
      return -1;
   endfunction

   function automatic bit anyact();
      for (int i = 0; i < NREQ; i++)
         if (act[i] || q_cnt[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic load(int i, int l4);
      pw[i][0] = ($urandom() & 32'hFFFF_FFF0) | 32'(l4);
      for (int n = 1; n < 18; n++) pw[i][n] = $urandom();
      len[i]   = l4 + 3;
      idx[i]   = 0;
      act[i]   = 1'b1;
      xdone[i] = 1'b0;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         if (!act[i] && q_cnt[i] > 0) begin
            q_cnt[i]--;
            load(i, $urandom_range(0, 15));
         end
         dwr_req[i]          = 1'b0;
         dwr_vout[i]         = 1'b0;
         dwr_dout[32*i +: 32] = '0;
         dwr_strb[4*i +: 4]   = '0;
         if (act[i]) begin
            if (drop_at[i] >= 0 && idx[i] >= drop_at[i]) begin
               act[i] = 1'b0;
            end else if (idx[i] >= len[i]) begin
               if (xtra[i] && !xdone[i]) begin
                  xdone[i]             = 1'b1;
                  dwr_req[i]           = 1'b1;
                  dwr_vout[i]          = 1'b1;
                  dwr_dout[32*i +: 32] = 32'hBAD0_0000;
                  dwr_strb[4*i +: 4]   = 4'hF;
               end else begin
                  act[i] = 1'b0;
               end
            end else begin
               dwr_req[i]           = 1'b1;
               dwr_vout[i]          = dwr_ack[i];
               dwr_dout[32*i +: 32] = pw[i][idx[i]];
               dwr_strb[4*i +: 4]   = sb(pw[i][idx[i]]);
            end
         end
      end
   endtask

   task automatic monitor();
      logic [NREQ-1:0] e_ack;
      int g;
      check("ack_onehot", 64'($onehot0(dwr_ack)), 1);
      if (dwr_ack != '0 && p_ack == '0) begin
         if (pend >= 0) mrr = pend;
         g = (s_free >= FW'(MAXLEN)) ? pick(s_req, mrr) : -1;
         e_ack = (g >= 0) ? (NREQ'(1) << g) : '0;
         check("grant", dwr_ack, e_ack);
         check("gnt_id", gnt_id, g);
         glog.push_back(int'(gnt_id));
         owner = g;
         k = 0;
         pend = (g >= 0) ? (g + 1) % NREQ : -1;
      end
      if (m_vout) begin
         fwd_cnt++;
         if (owner < 0 || k >= len[owner]) begin
            check("fwd_stray", m_vout, 0);
         end else begin
            check("m_dout", m_dout, pw[owner][k]);
            check("m_strb", m_strb, sb(pw[owner][k]));
            check("m_sop", m_sop, k == 0);
            check("m_eop", m_eop, k == len[owner] - 1);
            if (k == len[owner] - 1) done_cnt[owner]++;
            k++;
         end
      end else begin
         check("m_idle", {m_dout, m_strb, m_sop, m_eop}, 0);
      end
      if (!enb || !rst_n) begin
         check("off_vout", m_vout, 0);
         mrr = 0;
         pend = -1;
         owner = -1;
      end
      p_ack = dwr_ack;
   endtask

   task automatic tick();
      @(posedge clk);
      s_req  = dwr_req;
      s_free = m_free;
      #1;
      for (int i = 0; i < NREQ; i++)
         if (dwr_vout[i]) idx[i]++;
      drive();
      @(negedge clk);
      monitor();
   endtask

   task automatic wait_idle(string nm, int lim);
      int n = 0;
      while ((busy || anyact()) && n < lim) begin
         tick();
         n++;
      end
      check({nm, "_timeout"}, 64'(n < lim), 1);
   endtask

   typedef struct {
      int id;
      int l4;
      int mfree;
      int words;
   } vec_t;

   vec_t tv [6];
   int   seq [5] = '{0, 1, 2, 3, 0};

   initial begin
      #500000;
      $display("FAIL watchdog: no finish by time limit");
      $fatal(1);
   end

   initial begin
      int c0;
      int n;
      int tot [NREQ];
      int base [NREQ];

      tv[0] = '{0, 0, 64, 3};
      tv[1] = '{3, 7, 18, 10};
      tv[2] = '{2, 15, 1023, 18};
      tv[3] = '{1, 5, 17, 0};
      tv[4] = '{1, 1, 200, 4};
      tv[5] = '{3, 15, 0, 0};

      for (int i = 0; i < NREQ; i++) begin
         drop_at[i] = -1;
         done_cnt[i] = 0;
      end
      rst_n = 1'b0; enb = 1'b1; m_free = 64;
      dwr_req = '0; dwr_vout = '0; dwr_dout = '0; dwr_strb = '0;
      p_ack = '0; s_req = '0; s_free = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ack", dwr_ack, 0);
      check("rst_busy", busy, 0);
      check("rst_gnt", gnt_id, 0);
      check("rst_err", err_len, 0);
      check("rst_mout", {m_vout, m_dout, m_strb, m_sop, m_eop}, 0);
      #1 rst_n = 1'b1;
      tick();

      // single 18-word packet
      load(0, 15);
      tick();
      check("t1_noack", dwr_ack, 0);
      tick();
      check("t1_ack", dwr_ack, 4'b0001);
      check("t1_sop", m_sop, 1);
      n = m_vout ? 1 : 0;
      for (int i = 0; i < 17; i++) begin
         tick();
         if (m_vout) n++;
      end
      check("t1_words", n, 18);
      check("t1_eop", m_eop, 1);
      tick();
      check("t1_ack_off", dwr_ack, 0);
      check("t1_vout_off", m_vout, 0);
      wait_idle("t1", 20);

      // vector table: length field and m_free threshold
      for (int v = 0; v < 6; v++) begin
         m_free = FW'(tv[v].mfree);
         c0 = fwd_cnt;
         load(tv[v].id, tv[v].l4);
         repeat (tv[v].l4 + 8) tick();
         check($sformatf("tv%0d_words", v), fwd_cnt - c0, tv[v].words);
         check($sformatf("tv%0d_busy", v), busy, 0);
         act[tv[v].id] = 1'b0;
         m_free = 64;
         tick();
         wait_idle($sformatf("tv%0d", v), 20);
      end

      // m_free just below then at threshold
      m_free = 17;
      load(1, 15);
      repeat (4) tick();
      check("t3_noack", dwr_ack, 0);
      m_free = 18;
      tick();
      check("t3_ack", dwr_ack, 4'b0010);
      m_free = 64;
      wait_idle("t3", 40);

      // all requesters at once, pointer cleared first
      enb = 1'b0;
      tick();
      enb = 1'b1;
      glog.delete();
      for (int i = 0; i < NREQ; i++) load(i, 15);
      q_cnt[0] = 1;
      wait_idle("t2", 200);
      check("t2_ngrants", glog.size(), 5);
      for (int j = 0; j < 5; j++)
         if (j < glog.size()) check($sformatf("t2_seq%0d", j), glog[j], seq[j]);

      // requester drops early
      c0 = fwd_cnt;
      load(2, 15);
      drop_at[2] = 10;
      wait_idle("t4", 60);
      drop_at[2] = -1;
      check("t4_words", fwd_cnt - c0, 10);
      check("t4_err", err_len, 1);
      check("t4_ack", dwr_ack, 0);
      c0 = fwd_cnt;
      load(3, 2);
      wait_idle("t4b", 30);
      check("t4_next_words", fwd_cnt - c0, 5);
      check("t4_err_sticky", err_len, 1);
      enb = 1'b0;
      tick();
      enb = 1'b1;
      check("t4_err_clr", err_len, 0);

      // forced word after count complete
      c0 = fwd_cnt;
      load(0, 3);
      xtra[0] = 1'b1;
      wait_idle("t5", 30);
      xtra[0] = 1'b0;
      check("t5_words", fwd_cnt - c0, 6);
      check("t5_err", err_len, 1);

      // enb abort mid-packet
      load(1, 15);
      repeat (6) tick();
      check("t6_busy", busy, 1);
      enb = 1'b0;
      act[1] = 1'b0;
      tick();
      check("t6_ack", dwr_ack, 0);
      check("t6_nbusy", busy, 0);
      check("t6_err", err_len, 0);
      check("t6_gnt", gnt_id, 0);
      enb = 1'b1;
      load(0, 1);
      load(3, 1);
      tick();
      tick();
      check("t6_rr0", dwr_ack, 4'b0001);
      wait_idle("t6", 30);

      // asynchronous reset mid-packet
      load(2, 15);
      repeat (6) tick();
      #2 rst_n = 1'b0;
      act[2] = 1'b0;
      #1;
      check("t7_ack", dwr_ack, 0);
      check("t7_busy", busy, 0);
      check("t7_vout", m_vout, 0);
      tick();
      #2 rst_n = 1'b1;
      tick();

      // randomized traffic
      for (int i = 0; i < NREQ; i++) begin
         q_cnt[i] = $urandom_range(3, 6);
         tot[i]   = q_cnt[i];
         base[i]  = done_cnt[i];
      end
      n = 0;
      while ((busy || anyact()) && n < 4000) begin
         if ($urandom_range(0, 3) == 0) m_free = FW'($urandom_range(0, 17));
         else m_free = FW'($urandom_range(18, 1023));
         tick();
         n++;
      end
      check("rnd_timeout", 64'(n < 4000), 1);
      for (int i = 0; i < NREQ; i++)
         check($sformatf("rnd_done%0d", i), done_cnt[i] - base[i], tot[i]);
      check("rnd_err", err_len, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
